xi_ext_req_queue: RTL and testbench

- Elastic request queue between the multicore engine's fire-and-forget external-memory port (ext_rd_en / ext_wr_en pulses, no ready) and the AXI4 memory bridge FSM, which accepts one request at a time via valid/ready.
- Buffers reads and writes in strict program order.
- Presents the head entry to the bridge first-word-fall-through.
- Registers read responses back to the engine.
- Raises sticky error flags on overflow and on responses with no read outstanding.

---
 rtl/xi_ext_req_queue_if.sv | 21 ++
 rtl/xi_ext_req_queue.sv | 157 +++++++++++++++
 tb/tb_xi_ext_req_queue.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/xi_ext_req_queue_if.sv
// xi_ext_req_queue_if: request/response channel between the engine request queue and the AXI4 memory bridge
interface xi_ext_req_queue_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 160
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  modport master (
    output req_valid, req_is_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_is_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/xi_ext_req_queue.sv
// xi_ext_req_queue: in-order elastic read/write request queue feeding the memory bridge (XI_EXTQ_STATS_EN adds counters)
module xi_ext_req_queue #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 160,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_clr_err,
  input  logic                       i_ext_rd_en,
  input  logic [ADDR_W-1:0]          i_ext_rd_addr,
  input  logic                       i_ext_wr_en,
  input  logic [ADDR_W-1:0]          i_ext_wr_addr,
  input  logic [DATA_W-1:0]          i_ext_wr_data,
  output logic [DATA_W-1:0]          o_ext_rd_data,
  output logic                       o_ext_rd_valid,
  output logic                       o_almost_full,
  output logic [$clog2(DEPTH):0]     o_occupancy,
  output logic                       o_overflow,
  output logic                       o_unexpected_rsp,
`ifdef XI_EXTQ_STATS_EN
  output logic [31:0]                o_stat_reads,
  output logic [31:0]                o_stat_writes,
  output logic [$clog2(DEPTH):0]     o_stat_max_occ,
`endif
  xi_ext_req_queue_if.master         bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = AW + 2;

  logic              r_is_wr [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];
  logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [OW-1:0]     r_occ;
  logic [CW-1:0]     r_outst;
  logic              r_ovf, r_unexp, r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_valid, w_pop, w_rd_pop, w_push_wr, w_push_rd;
  logic              w_ovf_set, w_unexp_set;
  logic [OW-1:0]     w_free;
  logic [AW-1:0]     w_rd_slot;

  assign w_valid     = r_occ != '0;
  assign w_pop       = w_valid && bus.req_ready && !i_flush;
  assign w_rd_pop    = w_pop && !r_is_wr[r_rd_ptr];
  // a pop in the same cycle frees a slot for the incoming push
  assign w_free      = OW'(DEPTH) - r_occ + OW'(w_pop);
  assign w_push_wr   = i_ext_wr_en && !i_flush && w_free != '0;
  // the read lands behind a same-cycle write, so it needs one more free slot
  assign w_push_rd   = i_ext_rd_en && !i_flush && w_free > OW'(w_push_wr);
  assign w_rd_slot   = r_wr_ptr + AW'(w_push_wr);
  assign w_ovf_set   = !i_flush && ((i_ext_wr_en && !w_push_wr) || (i_ext_rd_en && !w_push_rd));
  assign w_unexp_set = bus.rsp_valid && !w_rd_pop && r_outst == '0;

  // head fields forced to zero when empty so nothing stale leaks to the bridge
  assign bus.req_valid    = w_valid;
  assign bus.req_is_wr    = w_valid ? r_is_wr[r_rd_ptr] : 1'b0;
  assign bus.req_addr     = w_valid ? r_addr[r_rd_ptr]  : '0;
  assign bus.req_wdata    = w_valid ? r_wdata[r_rd_ptr] : '0;
  assign o_occupancy      = r_occ;
  assign o_almost_full    = r_occ >= OW'(AFULL_THRESH);
  assign o_overflow       = r_ovf;
  assign o_unexpected_rsp = r_unexp;
  assign o_ext_rd_data    = r_rd_data;
  assign o_ext_rd_valid   = r_rd_valid;

  // entry storage: write at tail, read at tail+1 when both arrive together
  always_ff @(posedge clk) begin
    if (w_push_wr) begin
      r_is_wr[r_wr_ptr] <= 1'b1;
      r_addr[r_wr_ptr]  <= i_ext_wr_addr;
      r_wdata[r_wr_ptr] <= i_ext_wr_data;
    end
    if (w_push_rd) begin
      r_is_wr[w_rd_slot] <= 1'b0;
      r_addr[w_rd_slot]  <= i_ext_rd_addr;
      r_wdata[w_rd_slot] <= '0;
    end
  end

  // pointers and occupancy; flush empties the queue without popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_wr) + AW'(w_push_rd);
      r_occ    <= r_occ + OW'(w_push_wr) + OW'(w_push_rd) - OW'(w_pop);
    end
  end

  // outstanding reads survive flush since their responses are still coming back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_outst <= '0;
    else if (w_rd_pop && !bus.rsp_valid) r_outst <= r_outst + 1'b1;
    else if (!w_rd_pop && bus.rsp_valid && r_outst != '0) r_outst <= r_outst - 1'b1;
  end

  // read response is registered once and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rsp_valid;
      if (bus.rsp_valid) r_rd_data <= bus.rsp_data;
    end
  end

  // sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_unexp <= 1'b0;
    end else begin
      r_ovf   <= w_ovf_set   || (r_ovf   && !i_clr_err);
      r_unexp <= w_unexp_set || (r_unexp && !i_clr_err);
    end
  end

`ifdef XI_EXTQ_STATS_EN
  logic [31:0] r_stat_reads, r_stat_writes;
  logic [OW-1:0] r_stat_max;

  assign o_stat_reads   = r_stat_reads;
  assign o_stat_writes  = r_stat_writes;
  assign o_stat_max_occ = r_stat_max;

  // accepted-enqueue counters and occupancy high-water mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
      r_stat_max    <= '0;
    end else if (i_clr_err) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
      r_stat_max    <= '0;
    end else begin
      r_stat_reads  <= r_stat_reads + 32'(w_push_rd);
      r_stat_writes <= r_stat_writes + 32'(w_push_wr);
      r_stat_max    <= r_occ > r_stat_max ? r_occ : r_stat_max;
    end
  end
`endif
endmodule

// File: tb/tb_xi_ext_req_queue.sv
// tb_xi_ext_req_queue: directed self-checking bench for the external request queue
module tb_xi_ext_req_queue;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0, clr_err = 1'b0;
  logic         rd_en = 1'b0, wr_en = 1'b0;
  logic [19:0]  rd_addr = '0, wr_addr = '0;
  logic [159:0] wr_data = '0;
  logic [159:0] rd_data;
  logic         rd_valid, afull, ovf, unexp;
  logic [3:0]   occ;
  int           n_vec = 0;
  int           n_err = 0;
`ifdef XI_EXTQ_STATS_EN
  logic [31:0]  st_rd, st_wr;
  logic [3:0]   st_max;
`endif

  xi_ext_req_queue_if #(.ADDR_W(20), .DATA_W(160)) bus ();

  xi_ext_req_queue dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_clr_err(clr_err),
    .i_ext_rd_en(rd_en), .i_ext_rd_addr(rd_addr),
    .i_ext_wr_en(wr_en), .i_ext_wr_addr(wr_addr), .i_ext_wr_data(wr_data),
    .o_ext_rd_data(rd_data), .o_ext_rd_valid(rd_valid),
    .o_almost_full(afull), .o_occupancy(occ),
    .o_overflow(ovf), .o_unexpected_rsp(unexp),
`ifdef XI_EXTQ_STATS_EN
    .o_stat_reads(st_rd), .o_stat_writes(st_wr), .o_stat_max_occ(st_max),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    tick();
    tick();
    chk("rst_occ", occ, 0);
    chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unexp", unexp, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_afull", afull, 0);
    rst_n = 1'b1;
    tick();

    // single write with ready high
    bus.req_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 20'h00010; wr_data = {20{8'hA5}};
    tick();
    wr_en = 1'b0;
    chk("w1_valid", bus.req_valid, 1);
    chk("w1_is_wr", bus.req_is_wr, 1);
    chk("w1_addr", bus.req_addr, 20'h00010);
    chk("w1_wdata", bus.req_wdata, {20{8'hA5}});
    tick();
    chk("w1_occ_after_pop", occ, 0);
    chk("w1_valid_after_pop", bus.req_valid, 0);

    // simultaneous write+read: write first, then read
    bus.req_ready = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; wr_addr = 20'h22; rd_addr = 20'h22; wr_data = 160'h5555;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("wr_rd_occ", occ, 2);
    chk("wr_rd_head_is_wr", bus.req_is_wr, 1);
    chk("wr_rd_head_addr", bus.req_addr, 20'h22);
    tick();
    chk("wr_rd_head_stable", bus.req_wdata, 160'h5555);
    bus.req_ready = 1'b1;
    tick();
    chk("wr_rd_second_is_rd", bus.req_is_wr, 0);
    chk("wr_rd_second_addr", bus.req_addr, 20'h22);
    chk("wr_rd_occ1", occ, 1);
    tick();
    bus.req_ready = 1'b0;
    chk("wr_rd_occ0", occ, 0);
    bus.rsp_valid = 1'b1; bus.rsp_data = 160'h1234;
    chk("rsp_not_early", rd_valid, 0);
    tick();
    bus.rsp_valid = 1'b0;
    chk("rsp_valid", rd_valid, 1);
    chk("rsp_data", rd_data, 160'h1234);
    chk("rsp_no_unexp", unexp, 0);
    tick();
    chk("rsp_pulse_end", rd_valid, 0);
    chk("rsp_data_hold", rd_data, 160'h1234);

    // fill past full
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; wr_addr = 20'(i); wr_data = 160'(i);
      tick();
      chk("fill_occ", occ, i > 8 ? 8 : i);
      chk("fill_afull", afull, i >= 6);
      chk("fill_ovf", ovf, i == 9);
    end
    wr_en = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("full_head", bus.req_addr, 20'd1);

    // push into full queue with same-cycle pop
    bus.req_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 20'h99; wr_data = 160'h99;
    tick();
    wr_en = 1'b0;
    chk("fullpop_occ", occ, 8);
    chk("fullpop_ovf", ovf, 0);
    for (int i = 2; i <= 8; i++) begin
      chk("drain_addr", bus.req_addr, 20'(i));
      chk("drain_data", bus.req_wdata, 160'(i));
      tick();
    end
    chk("drain_last", bus.req_addr, 20'h99);
    tick();
    chk("drain_empty", occ, 0);
    bus.req_ready = 1'b0;

    // response with nothing outstanding
    bus.rsp_valid = 1'b1; bus.rsp_data = 160'hBEEF;
    tick();
    bus.rsp_valid = 1'b0;
    chk("unexp_set", unexp, 1);
    chk("unexp_rd_valid", rd_valid, 1);
    chk("unexp_rd_data", rd_data, 160'hBEEF);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unexp_clr", unexp, 0);

    // outstanding read, then flush a queue of 3
    bus.req_ready = 1'b1;
    rd_en = 1'b1; rd_addr = 20'h40;
    tick();
    rd_en = 1'b0;
    tick();
    bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 20'(i + 'h50);
      tick();
    end
    chk("pre_flush_occ", occ, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_occ", occ, 0);
    chk("flush_valid", bus.req_valid, 0);
    chk("flush_no_ovf", ovf, 0);
    bus.rsp_valid = 1'b1; bus.rsp_data = 160'h77;
    tick();
    bus.rsp_valid = 1'b0;
    chk("flush_rsp_valid", rd_valid, 1);
    chk("flush_rsp_data", rd_data, 160'h77);
    chk("flush_rsp_no_unexp", unexp, 0);

    // write+read with a single free slot: read dropped
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_addr = 20'(i);
      tick();
    end
    rd_en = 1'b1; rd_addr = 20'h60;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("oneslot_occ", occ, 8);
    chk("oneslot_ovf", ovf, 1);

    // asynchronous reset mid-transfer, then a stray response
    #2 rst_n = 1'b0;
    #1;
    chk("arst_occ", occ, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_valid", bus.req_valid, 0);
    tick();
    rst_n = 1'b1;
    bus.rsp_valid = 1'b1; bus.rsp_data = 160'h3;
    tick();
    bus.rsp_valid = 1'b0;
    chk("post_rst_unexp", unexp, 1);
    chk("post_rst_rd_data", rd_data, 160'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
